tmr_cnt_core: RTL and testbench
===============================

// Module: tmr_cnt_core
// PURPOSE
//  - 8-bit timer counter stage. Sits directly downstream of the edge detector and consumes its
//    one-pclk TMR_Edge pulse as the count tick.
//  - Counts up or down, supports a parallel load from TDR, and raises sticky overflow/underflow
//    flags plus one-cycle interrupt pulses.
// PARAMETERS
//  - WIDTH     8     counter/TDR width in bits (all rules below stated for WIDTH=8)
//  - RST_VAL   8'h00 value of tcnt after reset
// PORTS
//  - pclk      in   1      system clock, the only clock
//  - preset    in   1      reset; synchronous, active-high
//  - TMR_Edge  in   1      count tick, one pclk wide, from the edge-detect stage
//  - en        in   1      count enable (level)
//  - dir       in   1      0 = count up, 1 = count down
//  - load      in   1      pulse: copy tdr into tcnt
//  - tdr       in   WIDTH  load value
//  - clr_ovf   in   1      pulse: clear ovf_flag
//  - clr_udf   in   1      pulse: clear udf_flag
//  - tcnt      out  WIDTH  current count, registered
//  - ovf_flag  out  1      sticky overflow flag
//  - udf_flag  out  1      sticky underflow flag
//  - ovf_int   out  1      one-cycle overflow interrupt pulse
//  - udf_int   out  1      one-cycle underflow interrupt pulse
// BEHAVIOUR
//  - Reset:
//    - preset high at a pclk edge forces tcnt=RST_VAL, both flags=0, both int pulses=0,
//      FSM=IDLE.
//    - Reset mid-count aborts the count; no flag or pulse is produced in that cycle.
//  - All outputs are registered. A tick sampled at pclk edge k is visible on tcnt after edge k
//    (1-cycle latency). Flags and int pulses update on the same edge as the wrap.
//  - FSM states: IDLE, RUN, DONE (DONE exists only with TMR_ONESHOT_EN).
//    - IDLE -> RUN when en=1.
//    - RUN -> IDLE when en=0.
//    - RUN -> DONE on a wrap in one-shot mode.
//    - DONE -> IDLE when en=0.
//    - Ticks are counted only in RUN.
//  - Count rules in RUN when TMR_Edge=1:
//    - up: tcnt+1 mod 2^WIDTH
//    - down: tcnt-1 mod 2^WIDTH
//  - Overflow: up, tick, tcnt=8'hFF -> tcnt=8'h00, ovf_flag=1, ovf_int=1 for exactly one cycle.
//  - Underflow: down, tick, tcnt=8'h00 -> tcnt=8'hFF, udf_flag=1, udf_int=1 for exactly one cycle.
//  - Load:
//    - load=1 writes tdr into tcnt on the next edge in any state.
//    - Load has priority over a simultaneous tick. That tick is dropped, with no wrap and no flag.
//  - Flags:
//    - Flags stay set until cleared.
//    - If set and clear occur in the same cycle, set wins (flag stays 1, int pulses).
//    - clr with the flag already 0 has no effect.
//  - dir changes take effect at the next tick. No tick in flight is lost or doubled.
//  - en=0 freezes tcnt (load still works). Re-enabling resumes from the held value.
// CONFIGURATION
//  - TMR_ONESHOT_EN defined:
//    - Adds an input oneshot (1 bit).
//    - With oneshot=1, the first overflow/underflow sets the flag/int, moves the FSM to DONE and
//      freezes tcnt at the wrapped value (8'h00 up / 8'hFF down).
//    - Further ticks are ignored until en is dropped.
//    - Load is still honoured in DONE.
//  - TMR_ONESHOT_EN undefined:
//    - No oneshot port and no DONE state.
//    - The counter free-runs and wraps continuously.
// TESTING
//  - Reset:
//    - Count to 8'h37, assert preset for 1 cycle.
//    - Next cycle: tcnt=8'h00, flags=0, ints=0.
//    - Ticks ignored until en is re-seen.
//  - Up overflow:
//    - load tdr=8'hFE, dir=0, en=1, two ticks.
//    - Expected tcnt FE->FF->00, ovf_flag=1, ovf_int high exactly 1 cycle.
//  - Down underflow:
//    - load tdr=8'h01, dir=1, two ticks.
//    - Expected tcnt 01->00->FF, udf_flag=1, udf_int 1 cycle, ovf_flag unchanged.
//  - Collisions:
//    - load(tdr=8'h80) with a tick in the same cycle -> tcnt=8'h80, not 8'h81.
//    - clr_ovf in the wrap cycle -> ovf_flag=1.
//  - Enable gating:
//    - en=0 with 5 ticks -> tcnt unchanged.
//    - en=1 with 3 ticks -> tcnt +3.
//  - One-shot (TMR_ONESHOT_EN, oneshot=1):
//    - From 8'hFF, 4 ticks -> tcnt=8'h00, FSM=DONE, ovf_int pulses once.
//    - en 0->1 resumes counting.

Source files
------------

// File: rtl/tmr_cnt_core.sv
// rtl/tmr_cnt_core.sv - 8-bit up/down timer counter with load, sticky wrap flags and wrap interrupts
// Optional one-shot mode (oneshot input, DONE state) is built when TMR_ONESHOT_EN is defined.
module tmr_cnt_core #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             TMR_Edge,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    input  logic             clr_ovf,
    input  logic             clr_udf,
`ifdef TMR_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic [WIDTH-1:0] tcnt,
    output logic             ovf_flag,
    output logic             udf_flag,
    output logic             ovf_int,
    output logic             udf_int
);

`ifdef TMR_ONESHOT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t state;
    logic   count_tick;
    logic   wrap_ovf;
    logic   wrap_udf;
    logic   stop_on_wrap;

    // A load in the same cycle swallows the tick, so it can never cause a wrap.
    always_comb begin
        count_tick = (state == RUN) && en && TMR_Edge && !load;
        wrap_ovf   = count_tick && !dir && (tcnt == {WIDTH{1'b1}});
        wrap_udf   = count_tick && dir && (tcnt == {WIDTH{1'b0}});
`ifdef TMR_ONESHOT_EN
        stop_on_wrap = oneshot && (wrap_ovf || wrap_udf);
`else
        stop_on_wrap = 1'b0;
`endif
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            tcnt     <= RST_VAL;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
            ovf_int  <= 1'b0;
            udf_int  <= 1'b0;
        end else begin
            ovf_int  <= wrap_ovf;
            udf_int  <= wrap_udf;
            ovf_flag <= wrap_ovf | (ovf_flag & ~clr_ovf);
            udf_flag <= wrap_udf | (udf_flag & ~clr_udf);

            if (load) begin
                tcnt <= tdr;
            end else if (count_tick) begin
                tcnt <= dir ? (tcnt - 1'b1) : (tcnt + 1'b1);
            end

            case (state)
                IDLE: if (en) state <= RUN;
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (stop_on_wrap) begin
`ifdef TMR_ONESHOT_EN
                        state <= DONE;
`else
                        state <= RUN;
`endif
                    end
                end
`ifdef TMR_ONESHOT_EN
                DONE: if (!en) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_cnt_core.sv
// tb/tb_tmr_cnt_core.sv - scoreboard bench for tmr_cnt_core; one-shot steps built with TMR_ONESHOT_EN
module tb_tmr_cnt_core;

    logic       pclk = 1'b0;
    logic       preset, tick, en, dir, load, clr_ovf, clr_udf;
    logic [7:0] tdr;
    logic       os = 1'b0;
    logic [7:0] tcnt;
    logic       ovf_flag, udf_flag, ovf_int, udf_int;

    always #5 pclk = ~pclk;

    tmr_cnt_core #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .TMR_Edge (tick),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .tdr      (tdr),
        .clr_ovf  (clr_ovf),
        .clr_udf  (clr_udf),
`ifdef TMR_ONESHOT_EN
        .oneshot  (os),
`endif
        .tcnt     (tcnt),
        .ovf_flag (ovf_flag),
        .udf_flag (udf_flag),
        .ovf_int  (ovf_int),
        .udf_int  (udf_int)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovf;
        logic       udf;
        logic       oi;
        logic       ui;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // Reference model: 0 = idle, 1 = run, 2 = done
    int         m_state = 0;
    logic [7:0] m_cnt = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       cur_en = 1'b0;
    logic       cur_dir = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic rst, input logic tk, input logic ld, input logic [7:0] t,
                        input logic co, input logic cu);
        exp_t e;
        exp_t got;
        logic cnt_ok, wo, wu;
        preset = rst; tick = tk; load = ld; tdr = t; clr_ovf = co; clr_udf = cu;
        en = cur_en; dir = cur_dir;
        if (rst) begin
            m_state = 0; m_cnt = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
            wo = 1'b0; wu = 1'b0;
        end else begin
            cnt_ok = (m_state == 1) && cur_en && tk && !ld;
            wo = cnt_ok && !cur_dir && (m_cnt == 8'hFF);
            wu = cnt_ok && cur_dir && (m_cnt == 8'h00);
            case (m_state)
                0: if (cur_en) m_state = 1;
                1: if (!cur_en) m_state = 0; else if (os && (wo || wu)) m_state = 2;
                default: if (!cur_en) m_state = 0;
            endcase
            if (ld) m_cnt = t;
            else if (cnt_ok) m_cnt = cur_dir ? m_cnt - 8'd1 : m_cnt + 8'd1;
            m_ovf = wo | (m_ovf & ~co);
            m_udf = wu | (m_udf & ~cu);
        end
        e.cnt = m_cnt; e.ovf = m_ovf; e.udf = m_udf; e.oi = wo; e.ui = wu;
        sb.push_back(e);
        @(posedge pclk);
        #1;
        got = sb.pop_front();
        chk("tcnt", tcnt, got.cnt);
        chk("ovf_flag", {7'd0, ovf_flag}, {7'd0, got.ovf});
        chk("udf_flag", {7'd0, udf_flag}, {7'd0, got.udf});
        chk("ovf_int", {7'd0, ovf_int}, {7'd0, got.oi});
        chk("udf_int", {7'd0, udf_int}, {7'd0, got.ui});
    endtask

    initial begin
        preset = 1'b1; tick = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
        tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0;

        step(1, 0, 0, 8'h00, 0, 0);
        step(1, 0, 0, 8'h00, 0, 0);
        chk("reset_tcnt", tcnt, 8'h00);

        // Count to 0x37, then reset mid-count with a tick present
        cur_en = 1'b1;
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 1, 8'h30, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00, 0, 0);
        chk("count_to_37", tcnt, 8'h37);
        step(1, 1, 0, 8'h00, 0, 0);
        chk("reset_mid_count", tcnt, 8'h00);
        chk("reset_no_int", {6'd0, ovf_int, udf_int}, 8'h00);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("rst_tick_ignored", tcnt, 8'h00);

        // Up overflow
        step(0, 0, 1, 8'hFE, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("up_ff", tcnt, 8'hFF);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("up_wrap", {tcnt[3:0], 2'b00, ovf_flag, ovf_int}, 8'h03);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("ovf_int_one_cycle", {6'd0, ovf_flag, ovf_int}, 8'h02);

        // Down underflow, ovf_flag left alone
        cur_dir = 1'b1;
        step(0, 0, 1, 8'h01, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("down_wrap", tcnt, 8'hFF);
        chk("udf_set_ovf_kept", {6'd0, ovf_flag, udf_flag}, 8'h03);
        step(0, 0, 0, 8'h00, 0, 0);

        // Load beats a simultaneous tick
        cur_dir = 1'b0;
        step(0, 1, 1, 8'h80, 0, 0);
        chk("load_vs_tick", tcnt, 8'h80);

        // Set beats clear in the wrap cycle
        step(0, 0, 0, 8'h00, 1, 0);
        step(0, 0, 1, 8'hFF, 0, 0);
        step(0, 1, 0, 8'h00, 1, 0);
        chk("set_beats_clr", {6'd0, ovf_flag, ovf_int}, 8'h03);

        // Clear with flag already clear is harmless
        step(0, 0, 0, 8'h00, 0, 1);
        step(0, 0, 0, 8'h00, 0, 1);

        // Direction change at the next tick
        step(0, 1, 0, 8'h00, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0);
        cur_dir = 1'b1;
        step(0, 1, 0, 8'h00, 0, 0);
        chk("dir_change", tcnt, 8'h01);

        // Enable gating
        cur_dir = 1'b0;
        cur_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 0, 0);
            step(0, 0, 0, 8'h00, 0, 0);
        end
        chk("en_freeze", tcnt, 8'h01);
        cur_en = 1'b1;
        step(0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00, 0, 0);
            step(0, 0, 0, 8'h00, 0, 0);
        end
        chk("en_resume", tcnt, 8'h04);

`ifdef TMR_ONESHOT_EN
        os = 1'b1;
        step(0, 0, 1, 8'hFF, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0, 0);
        chk("oneshot_hold", tcnt, 8'h00);
        cur_en = 1'b0;
        step(0, 0, 0, 8'h00, 0, 0);
        cur_en = 1'b1;
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("oneshot_resume", tcnt, 8'h01);
        os = 1'b0;
`endif

        for (int i = 0; i < 300; i++) begin
            cur_en  = ($urandom_range(0, 7) != 0);
            cur_dir = ($urandom_range(0, 3) == 0) ? ~cur_dir : cur_dir;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0), 8'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
